// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V
// corner-case results, an operand-reuse fast path and a flush input.
module iter_divider #(
  parameter int DATA_WIDTH = 32,
  parameter bit REUSE_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic [1:0]            funct_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(DATA_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
    return ~v + DATA_WIDTH'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic is_signed);
    return (is_signed && v[DATA_WIDTH-1]) ? negate(v) : v;
  endfunction

  state_t state_q, state_d;
  logic   busy_d, done_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q;
  logic                  neg_quo_q, neg_rem_q, sel_rem_q;
  logic [DATA_WIDTH-1:0] pend_a_q, pend_b_q;
  logic                  pend_u_q;

  // Reuse entry: operands, signedness and both results of the last completed op
  logic                  ent_vld_q;
  logic [DATA_WIDTH-1:0] ent_a_q, ent_b_q, ent_quo_q, ent_rem_q;
  logic                  ent_u_q;

  logic                  can_accept, accept, is_signed_in;
  logic                  reuse_hit, div_zero, sgn_ovf, fast_path;
  logic [DATA_WIDTH-1:0] fast_quo, fast_rem, quo_fix, rem_fix;
  logic [DATA_WIDTH:0]   shift_w, diff_w;

  assign can_accept   = (state_q == IDLE) || (state_q == DONE);
  assign accept       = can_accept && start_i && !flush_i;
  assign is_signed_in = ~funct_i[0];
  assign reuse_hit    = REUSE_EN && ent_vld_q && (op_a_i == ent_a_q) &&
                        (op_b_i == ent_b_q) && (funct_i[0] == ent_u_q);
  assign div_zero     = (op_b_i == '0);
  assign sgn_ovf      = is_signed_in && (op_a_i == MIN_NEG) && (op_b_i == '1);
  assign fast_path    = reuse_hit || div_zero || sgn_ovf;

  always_comb begin
    fast_quo = ent_quo_q;
    fast_rem = ent_rem_q;
    if (!reuse_hit) begin
      if (div_zero) begin
        fast_quo = '1;
        fast_rem = op_a_i;
      end else begin
        fast_quo = op_a_i;
        fast_rem = '0;
      end
    end
  end

  // One restoring step; the extra top bit keeps the trial subtraction exact
  assign shift_w = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff_w  = shift_w - {1'b0, div_q};
  assign quo_fix = neg_quo_q ? negate(quo_q) : quo_q;
  assign rem_fix = neg_rem_q ? negate(rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = fast_path ? DONE : CALC;
        else         state_d = IDLE;
      end
      CALC:    if (cnt_q == '0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    busy_d = (state_d == CALC) || (state_d == FIXUP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
      ent_vld_q <= 1'b0;
    end else begin
      busy_o <= busy_d;
      done_o <= done_d;
      if (flush_i)
        ent_vld_q <= 1'b0;
      else if ((accept && fast_path) || state_q == FIXUP)
        ent_vld_q <= 1'b1;
      if (accept) begin
        if (fast_path) result_q <= funct_i[1] ? fast_rem : fast_quo;
        else           cnt_q    <= CNT_INIT;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == FIXUP && !flush_i) begin
        result_q <= sel_rem_q ? rem_fix : quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_rem_q <= funct_i[1];
      if (fast_path) begin
        ent_a_q   <= op_a_i;
        ent_b_q   <= op_b_i;
        ent_u_q   <= funct_i[0];
        ent_quo_q <= fast_quo;
        ent_rem_q <= fast_rem;
      end else begin
        pend_a_q  <= op_a_i;
        pend_b_q  <= op_b_i;
        pend_u_q  <= funct_i[0];
        rem_q     <= '0;
        quo_q     <= magnitude(op_a_i, is_signed_in);
        div_q     <= magnitude(op_b_i, is_signed_in);
        neg_quo_q <= is_signed_in && (op_a_i[DATA_WIDTH-1] ^ op_b_i[DATA_WIDTH-1]);
        neg_rem_q <= is_signed_in && op_a_i[DATA_WIDTH-1];
      end
    end else if (state_q == CALC) begin
      rem_q <= diff_w[DATA_WIDTH] ? shift_w[DATA_WIDTH-1:0] : diff_w[DATA_WIDTH-1:0];
      quo_q <= {quo_q[DATA_WIDTH-2:0], ~diff_w[DATA_WIDTH]};
    end else if (state_q == FIXUP) begin
      ent_a_q   <= pend_a_q;
      ent_b_q   <= pend_b_q;
      ent_u_q   <= pend_u_q;
      ent_quo_q <= quo_fix;
      ent_rem_q <= rem_fix;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed scenarios plus a randomised
// sweep against an arithmetic reference model with last-op reuse tracking.
module tb_iter_divider;
  localparam int W        = 32;
  localparam bit REUSE    = 1'b1;
  localparam int LAT_FULL = W + 2;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic [1:0]   funct_i = 2'b00;
  logic         flush_i = 1'b0;
  logic         busy_o, done_o;
  logic [W-1:0] result_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory of the last completed operation
  logic         m_vld = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_u = 1'b0;

  iter_divider #(.DATA_WIDTH(W), .REUSE_EN(REUSE)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .funct_i(funct_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] f);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!f[0] && a == MINV && b == '1) begin
      q = a; r = '0;
    end else if (!f[0]) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] f);
    logic hit, ovf;
    hit = REUSE && m_vld && a == m_a && b == m_b && f[0] == m_u;
    ovf = !f[0] && a == MINV && b == '1;
    return (hit || b == '0 || ovf) ? 1 : LAT_FULL;
  endfunction

  task automatic model_commit(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    m_vld = 1'b1; m_a = a; m_b = b; m_u = f[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and waits for done; reports latency, result and busy-shape
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                       output int lat, output logic [W-1:0] res, output logic shape_ok);
    op_a_i = a; op_b_i = b; funct_i = f; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 1;
    shape_ok = 1'b1;
    while (done_o !== 1'b1 && lat < LAT_FULL + 20) begin
      if (busy_o !== 1'b1) shape_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy_o !== 1'b0) shape_ok = 1'b0;
    res = result_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result_o); end
    rst_n = 1'b1;
    m_vld = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int lat; logic [W-1:0] res; logic ok;
    do_op(32'd100, 32'd7, 2'b01, lat, res, ok);
    model_commit(32'd100, 32'd7, 2'b01);
    n_vec++; if (lat != LAT_FULL) begin n_err++; $display("FAIL divu_latency: got %0d expected %0d", lat, LAT_FULL); end
    n_vec++; if (res !== 32'd14) begin n_err++; $display("FAIL divu_result: got %h expected %h", res, 32'd14); end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL divu_busy_shape: got %b expected 1", ok); end
    tick();
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL done_single_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_signed_reuse();
    int lat; logic [W-1:0] res; logic ok;
    do_op(32'hFFFF_FFF9, 32'd2, 2'b00, lat, res, ok);
    model_commit(32'hFFFF_FFF9, 32'd2, 2'b00);
    n_vec++; if (lat != LAT_FULL) begin n_err++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT_FULL); end
    n_vec++; if (res !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_result: got %h expected fffffffd", res); end
    do_op(32'hFFFF_FFF9, 32'd2, 2'b10, lat, res, ok);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL rem_reuse_latency: got %0d expected 1", lat); end
    n_vec++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_reuse_result: got %h expected ffffffff", res); end
  endtask

  task automatic test_edge();
    int lat; logic [W-1:0] res; logic ok;
    do_op(32'h1234, 32'd0, 2'b01, lat, res, ok);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL divu0_latency: got %0d expected 1", lat); end
    n_vec++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_result: got %h expected ffffffff", res); end
    do_op(32'h1234, 32'd0, 2'b10, lat, res, ok);
    n_vec++; if (res !== 32'h1234) begin n_err++; $display("FAIL rem0_result: got %h expected 1234", res); end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rem0_busy_shape: got %b expected 1", ok); end
    do_op(MINV, 32'hFFFF_FFFF, 2'b00, lat, res, ok);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
    n_vec++; if (res !== MINV) begin n_err++; $display("FAIL ovf_div_result: got %h expected %h", res, MINV); end
    do_op(MINV, 32'hFFFF_FFFF, 2'b10, lat, res, ok);
    n_vec++; if (res !== 32'd0) begin n_err++; $display("FAIL ovf_rem_result: got %h expected 0", res); end
    model_commit(MINV, 32'hFFFF_FFFF, 2'b10);
  endtask

  task automatic test_flush();
    int lat, dones; logic [W-1:0] res; logic ok;
    do_op(32'd1000, 32'd3, 2'b01, lat, res, ok);
    model_commit(32'd1000, 32'd3, 2'b01);
    n_vec++; if (res !== 32'd333) begin n_err++; $display("FAIL flush_pre_result: got %h expected %h", res, 32'd333); end
    op_a_i = 32'd500; op_b_i = 32'd9; funct_i = 2'b01; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    m_vld = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
    n_vec++; if (result_o !== 32'd333) begin n_err++; $display("FAIL flush_result_held: got %h expected %h", result_o, 32'd333); end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) dones++;
      tick();
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL flush_no_done: got %0d expected 0", dones); end
    do_op(32'd1000, 32'd3, 2'b11, lat, res, ok);
    model_commit(32'd1000, 32'd3, 2'b11);
    n_vec++; if (lat != LAT_FULL) begin n_err++; $display("FAIL flush_reuse_invalid: got %0d expected %0d", lat, LAT_FULL); end
    n_vec++; if (res !== 32'd1) begin n_err++; $display("FAIL flush_remu_result: got %h expected 1", res); end
  endtask

  task automatic test_reset_mid();
    int dones; logic [W-1:0] res;
    op_a_i = 32'd200; op_b_i = 32'd6; funct_i = 2'b01; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_vld = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL midreset_result: got %h expected 0", result_o); end
    op_a_i = 32'd81; op_b_i = 32'd4; funct_i = 2'b01; start_i = 1'b1;
    tick();
    dones = 0;
    res = '0;
    for (int c = 1; c <= 45; c++) begin
      if (done_o === 1'b1) begin dones++; res = result_o; end
      start_i = (c == 3);
      if (c == 3) begin op_a_i = 32'd9; op_b_i = 32'd3; end
      tick();
    end
    start_i = 1'b0;
    model_commit(32'd81, 32'd4, 2'b01);
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL start_while_busy_dones: got %0d expected 1", dones); end
    n_vec++; if (res !== 32'd20) begin n_err++; $display("FAIL start_while_busy_result: got %h expected %h", res, 32'd20); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [W-1:0] res, exp_res, a, b, la, lb; logic [1:0] f; logic ok;
    la = 32'd1; lb = 32'd1;
    for (int i = 0; i < 300; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = '0; end
        1: begin a = MINV; b = '1; end
        2: begin a = la; b = lb; end
        3: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        4: begin a = $urandom; b = 32'($urandom_range(1, 7)) ^ (($urandom % 2 == 0) ? '0 : '1); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp_res = ref_result(a, b, f);
      exp_lat = ref_latency(a, b, f);
      do_op(a, b, f, lat, res, ok);
      model_commit(a, b, f);
      la = a; lb = b;
      n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL rand_result a=%h b=%h f=%0d: got %h expected %h", a, b, f, res, exp_res); end
      n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL rand_latency a=%h b=%h f=%0d: got %0d expected %0d", a, b, f, lat, exp_lat); end
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand_busy_shape a=%h b=%h: got %b expected 1", a, b, ok); end
      if ($urandom_range(0, 4) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_reuse();
    test_edge();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
